wave_capture_multi: RTL and testbench
=====================================

# wave_capture_multi

Parametrised successor to the single-mode wave capture block: watches a stream of signed audio samples, waits for a configurable trigger (rising/falling threshold crossing or auto-trigger timeout), then writes a window of 2^DEPTH_LOG2 offset-binary samples, optionally decimated, into one half of a double-buffered display RAM. It sits between the codec sample source and the wave display RAM/reader, handing the filled half to the display when the display reports idle.

## Interface
- SAMPLE_W, 16, input sample width (two's complement)
- OUT_W, 8, stored sample width (OUT_W <= SAMPLE_W)
- DEPTH_LOG2, 8, log2 of samples per capture window
- AUTO_TIMEOUT, 4096, sample pulses spent in ARMED before a forced trigger (>= 1)

- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- new_sample_ready  in  1  one-cycle pulse, new_sample_in valid
- new_sample_in  in  SAMPLE_W  signed sample
- trig_threshold  in  SAMPLE_W  signed trigger level
- trig_falling  in  1  0 = rising crossing, 1 = falling crossing
- auto_en  in  1  enable auto-trigger timeout
- decim  in  8  store every (decim+1)-th sample; 0 = every sample
- wave_display_idle  in  1  display finished reading its half
- write_address  out  DEPTH_LOG2+1  {bank, index}
- write_enable  out  1  one-cycle RAM write strobe
- write_sample  out  OUT_W  offset-binary sample
- read_index  out  1  bank the display reads; capture writes ~read_index
- capture_done  out  1  one-cycle pulse when last sample written
- auto_triggered  out  1  last capture was forced by timeout

## Operation
- States: ARMED, ACTIVE, WAIT. Reset -> ARMED.
- prev register holds last sample; updated on every new_sample_ready in every state. prev_valid set on first pulse after reset.
- ARMED, on pulse with prev_valid: rising trigger if prev < thr and cur >= thr; falling if prev >= thr and cur < thr (signed compares, full SAMPLE_W). On trigger: latch trig_falling-independent config (decim) into shadow register, write cur as index 0, index <= 1, dec_cnt <= 0, auto_triggered <= 0, go ACTIVE.
- Auto: timeout counter counts pulses in ARMED, cleared on ARMED entry. If auto_en and counter reaches AUTO_TIMEOUT-1 on a pulse with no real trigger, that sample triggers as above with auto_triggered <= 1. Real trigger wins if both.
- ACTIVE, on pulse: if dec_cnt == decim_latched, write sample at index, index++, dec_cnt <= 0; else dec_cnt++ (no write). Write of index 2^DEPTH_LOG2-1 -> capture_done pulse, go WAIT.
- Stored sample = new_sample_in[SAMPLE_W-1 -: OUT_W] with MSB inverted (equivalent to +2^(OUT_W-1) mod 2^OUT_W).
- write_address = {~read_index, index}.
- WAIT: no writes. wave_display_idle high -> toggle read_index, go ARMED. wave_display_idle ignored in ARMED and ACTIVE.
- Inputs trig_threshold, trig_falling, auto_en read live in ARMED; decim only latched at trigger.

## Timing
- All outputs registered. write_enable/write_address/write_sample valid the cycle after the new_sample_ready pulse that produced them; write_enable high exactly one cycle.
- capture_done asserts in same cycle as final write_enable.
- read_index toggles the cycle after wave_display_idle sampled high in WAIT; same edge state becomes ARMED.
- idle and new_sample_ready in same WAIT cycle: move to ARMED, sample not trigger-tested (prev still updated).
- Back-to-back pulses (every cycle) supported; one write per pulse maximum.
- Reset (any time, including mid-capture): state ARMED, write_enable 0, write_address 0, write_sample 0, read_index 0, capture_done 0, auto_triggered 0, prev_valid 0, all counters 0. Partial capture discarded.

## Test plan
- Defaults, thr=0, rising, decim=0: samples -5,-3,+2,... -> first write addr 9'h100 data 8'h80 (sample 0x0002 -> 0x80), 256 writes to 0x100..0x1FF, capture_done with last; idle pulse -> read_index=1, next capture writes 0x000..0x0FF.
- Falling, thr=0x1000: 0x2000 then 0x0800 triggers; 0x0800 stored as 8'h88; rising-only sequence produces no writes.
- Constant 0 input, auto_en=1, AUTO_TIMEOUT=16: trigger on 16th pulse in ARMED, auto_triggered=1; auto_en=0 -> no writes ever.
- decim=3: 1024 pulses after trigger yield 256 writes, on pulses 0,4,8,...; decim change mid-capture has no effect.
- Reset asserted at index 100 of capture: all outputs zero next cycle, read_index 0, next capture restarts at index 0 of bank 1 after trigger.
- WAIT with idle low for 1000 pulses: no writes, read_index stable; idle pulse coincident with a triggering sample does not trigger.

Source files
------------

// File: rtl/wave_capture_multi.sv
// wave_capture_multi
// Triggered capture of a signed sample stream into one half of a
// double-buffered display RAM. A window of 2^DEPTH_LOG2 offset-binary
// samples, optionally decimated, is written after a rising or falling
// threshold crossing, or after an auto-trigger timeout. The filled half
// is handed to the display when it reports idle.
module wave_capture_multi #(
    parameter int SAMPLE_W     = 16,
    parameter int OUT_W        = 8,
    parameter int DEPTH_LOG2   = 8,
    parameter int AUTO_TIMEOUT = 4096
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  new_sample_ready,
    input  logic [SAMPLE_W-1:0]   new_sample_in,
    input  logic [SAMPLE_W-1:0]   trig_threshold,
    input  logic                  trig_falling,
    input  logic                  auto_en,
    input  logic [7:0]            decim,
    input  logic                  wave_display_idle,
    output logic [DEPTH_LOG2:0]   write_address,
    output logic                  write_enable,
    output logic [OUT_W-1:0]      write_sample,
    output logic                  read_index,
    output logic                  capture_done,
    output logic                  auto_triggered
);

    // Timeout counter is wide enough to hold AUTO_TIMEOUT-1 and saturates there.
    localparam int                    TO_W     = $clog2(AUTO_TIMEOUT + 1);
    localparam logic [TO_W-1:0]       TO_LAST  = TO_W'(AUTO_TIMEOUT - 1);
    localparam logic [DEPTH_LOG2-1:0] IDX_LAST = {DEPTH_LOG2{1'b1}};

    typedef enum logic [1:0] {
        ST_ARMED  = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_WAIT   = 2'd2
    } state_t;

    state_t                  state_q;
    logic [SAMPLE_W-1:0]     prev_q;
    logic                    prev_valid_q;
    logic [DEPTH_LOG2-1:0]   index_q;
    logic [7:0]              dec_cnt_q;
    logic [7:0]              decim_q;
    logic [TO_W-1:0]         to_cnt_q;
    logic                    read_index_q;
    logic [DEPTH_LOG2:0]     write_address_q;
    logic                    write_enable_q;
    logic [OUT_W-1:0]        write_sample_q;
    logic                    capture_done_q;
    logic                    auto_triggered_q;

    logic signed [SAMPLE_W-1:0] cur_s;
    logic signed [SAMPLE_W-1:0] prev_s;
    logic signed [SAMPLE_W-1:0] thr_s;
    logic                       rise_s;
    logic                       fall_s;
    logic                       real_trig_s;
    logic                       auto_trig_s;
    logic                       dec_hit_s;
    logic [OUT_W-1:0]           stored_s;

    // Top OUT_W bits of the sample with the MSB flipped: two's complement
    // to offset binary.
    function automatic logic [OUT_W-1:0] to_offset_binary(input logic [SAMPLE_W-1:0] s);
        logic [OUT_W-1:0] top;
        top            = s[SAMPLE_W-1 -: OUT_W];
        top[OUT_W-1]   = ~top[OUT_W-1];
        return top;
    endfunction

    assign cur_s  = $signed(new_sample_in);
    assign prev_s = $signed(prev_q);
    assign thr_s  = $signed(trig_threshold);

    // Crossing tests need a valid previous sample; the timeout does not.
    assign rise_s      = prev_valid_q && (prev_s <  thr_s) && (cur_s >= thr_s);
    assign fall_s      = prev_valid_q && (prev_s >= thr_s) && (cur_s <  thr_s);
    assign real_trig_s = trig_falling ? fall_s : rise_s;
    assign auto_trig_s = auto_en && (to_cnt_q == TO_LAST);
    assign dec_hit_s   = (dec_cnt_q == decim_q);
    assign stored_s    = to_offset_binary(new_sample_in);

    // Capture FSM: trigger detection, decimated window writes and bank hand-off.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= ST_ARMED;
            prev_q           <= {SAMPLE_W{1'b0}};
            prev_valid_q     <= 1'b0;
            index_q          <= {DEPTH_LOG2{1'b0}};
            dec_cnt_q        <= 8'd0;
            decim_q          <= 8'd0;
            to_cnt_q         <= {TO_W{1'b0}};
            read_index_q     <= 1'b0;
            write_address_q  <= {(DEPTH_LOG2 + 1){1'b0}};
            write_enable_q   <= 1'b0;
            write_sample_q   <= {OUT_W{1'b0}};
            capture_done_q   <= 1'b0;
            auto_triggered_q <= 1'b0;
        end else begin
            write_enable_q <= 1'b0;
            capture_done_q <= 1'b0;

            // The previous-sample history tracks every pulse in every state.
            if (new_sample_ready) begin
                prev_q       <= new_sample_in;
                prev_valid_q <= 1'b1;
            end

            case (state_q)
                ST_ARMED: begin
                    if (new_sample_ready) begin
                        if (real_trig_s || auto_trig_s) begin
                            decim_q          <= decim;
                            write_enable_q   <= 1'b1;
                            write_address_q  <= {~read_index_q, {DEPTH_LOG2{1'b0}}};
                            write_sample_q   <= stored_s;
                            index_q          <= DEPTH_LOG2'(1);
                            dec_cnt_q        <= 8'd0;
                            auto_triggered_q <= ~real_trig_s;
                            to_cnt_q         <= {TO_W{1'b0}};
                            state_q          <= ST_ACTIVE;
                        end else if (to_cnt_q != TO_LAST) begin
                            to_cnt_q <= to_cnt_q + TO_W'(1);
                        end
                    end
                end
                ST_ACTIVE: begin
                    if (new_sample_ready) begin
                        if (dec_hit_s) begin
                            write_enable_q  <= 1'b1;
                            write_address_q <= {~read_index_q, index_q};
                            write_sample_q  <= stored_s;
                            index_q         <= index_q + DEPTH_LOG2'(1);
                            dec_cnt_q       <= 8'd0;
                            if (index_q == IDX_LAST) begin
                                capture_done_q <= 1'b1;
                                state_q        <= ST_WAIT;
                            end
                        end else begin
                            dec_cnt_q <= dec_cnt_q + 8'd1;
                        end
                    end
                end
                ST_WAIT: begin
                    // A pulse arriving with idle is not trigger-tested.
                    if (wave_display_idle) begin
                        read_index_q <= ~read_index_q;
                        to_cnt_q     <= {TO_W{1'b0}};
                        state_q      <= ST_ARMED;
                    end
                end
                default: begin
                    state_q <= ST_ARMED;
                end
            endcase
        end
    end

    assign write_address  = write_address_q;
    assign write_enable   = write_enable_q;
    assign write_sample   = write_sample_q;
    assign read_index     = read_index_q;
    assign capture_done   = capture_done_q;
    assign auto_triggered = auto_triggered_q;

endmodule

// File: tb/tb_wave_capture_multi.sv
// Self-checking bench for wave_capture_multi: directed scenarios with literal
// expectations plus a randomized soak, all checked every cycle against a
// behavioural model of the capture rules.
module tb_wave_capture_multi;

    localparam int SW = 16;
    localparam int OW = 8;
    localparam int DL = 8;
    localparam int AT = 16;
    localparam int N  = 1 << DL;
    localparam int SHIFT = SW - OW;

    logic          clk;
    logic          reset;
    logic          new_sample_ready;
    logic [SW-1:0] new_sample_in;
    logic [SW-1:0] trig_threshold;
    logic          trig_falling;
    logic          auto_en;
    logic [7:0]    decim;
    logic          wave_display_idle;
    logic [DL:0]   write_address;
    logic          write_enable;
    logic [OW-1:0] write_sample;
    logic          read_index;
    logic          capture_done;
    logic          auto_triggered;

    int n_checks = 0;
    int n_fail   = 0;
    int wr_cnt   = 0;

    // Behavioural model state (spec-level: pulses since trigger, bank, history)
    int m_state = 0;   // 0 armed, 1 active, 2 waiting for display
    int m_prev  = 0;
    bit m_pv    = 0;
    int m_tcnt  = 0;
    int m_since = 0;
    int m_decim = 0;
    int m_bank  = 0;
    bit e_we = 0, e_done = 0, e_auto = 0, e_ri = 0, e_rst = 0;
    int e_addr = 0, e_data = 0;
    bit model_live = 0;

    wave_capture_multi #(
        .SAMPLE_W    (SW),
        .OUT_W       (OW),
        .DEPTH_LOG2  (DL),
        .AUTO_TIMEOUT(AT)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .new_sample_ready (new_sample_ready),
        .new_sample_in    (new_sample_in),
        .trig_threshold   (trig_threshold),
        .trig_falling     (trig_falling),
        .auto_en          (auto_en),
        .decim            (decim),
        .wave_display_idle(wave_display_idle),
        .write_address    (write_address),
        .write_enable     (write_enable),
        .write_sample     (write_sample),
        .read_index       (read_index),
        .capture_done     (capture_done),
        .auto_triggered   (auto_triggered)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h want=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected stored value: arithmetic rescale to OUT_W bits plus mid-scale offset.
    task automatic model_write(input int idx, input int cur);
        e_we   = 1'b1;
        e_addr = ((1 - m_bank) * N) + idx;
        e_data = ((cur >>> SHIFT) + (1 << (OW - 1))) & ((1 << OW) - 1);
    endtask

    // Advance the model by one clock using the inputs the DUT will sample next edge.
    task automatic model_step();
        int cur, thr, k, orig;
        bit real_t, auto_t;
        e_we = 1'b0; e_done = 1'b0; e_rst = 1'b0;
        if (reset) begin
            m_state = 0; m_prev = 0; m_pv = 0; m_tcnt = 0; m_since = 0;
            m_bank = 0; e_auto = 1'b0; e_addr = 0; e_data = 0; e_rst = 1'b1;
        end else begin
            orig = m_state;
            cur  = int'($signed(new_sample_in));
            thr  = int'($signed(trig_threshold));
            if (new_sample_ready) begin
                if (orig == 0) begin
                    real_t = m_pv && (trig_falling ? (m_prev >= thr && cur < thr)
                                                   : (m_prev < thr && cur >= thr));
                    auto_t = auto_en && (m_tcnt >= AT - 1);
                    if (real_t || auto_t) begin
                        m_decim = int'(decim);
                        m_since = 1;
                        model_write(0, cur);
                        e_auto  = !real_t;
                        m_state = 1;
                    end else begin
                        m_tcnt++;
                    end
                end else if (orig == 1) begin
                    k = m_since;
                    m_since++;
                    if (k % (m_decim + 1) == 0) begin
                        model_write(k / (m_decim + 1), cur);
                        if (k / (m_decim + 1) == N - 1) begin
                            e_done  = 1'b1;
                            m_state = 2;
                        end
                    end
                end
                m_prev = cur;
                m_pv   = 1'b1;
            end
            if (orig == 2 && wave_display_idle) begin
                m_bank  = 1 - m_bank;
                m_state = 0;
                m_tcnt  = 0;
            end
        end
        e_ri = (m_bank != 0);
    endtask

    // Compare process: check last edge's outputs, then predict the next edge.
    initial begin
        forever begin
            @(negedge clk);
            if (model_live) begin
                chk("write_enable",   32'(write_enable),   32'(e_we));
                chk("capture_done",   32'(capture_done),   32'(e_done));
                chk("auto_triggered", 32'(auto_triggered), 32'(e_auto));
                chk("read_index",     32'(read_index),     32'(e_ri));
                if (e_we || e_rst) begin
                    chk("write_address", 32'(write_address), 32'(e_addr));
                    chk("write_sample",  32'(write_sample),  32'(e_data));
                end
            end
            if (write_enable) wr_cnt++;
            model_step();
            model_live = 1'b1;
        end
    end

    // Drive one clock's worth of inputs; returns just after the edge.
    task automatic cyc(input logic rdy, input logic [SW-1:0] v);
        new_sample_ready = rdy;
        new_sample_in    = v;
        @(posedge clk);
        #1;
    endtask

    // Stimulus: directed scenarios then randomized soak.
    initial begin
        int base;
        bit got;
        reset = 1'b1; new_sample_ready = 1'b0; new_sample_in = 16'h0000;
        trig_threshold = 16'h0000; trig_falling = 1'b0; auto_en = 1'b0;
        decim = 8'd0; wave_display_idle = 1'b0;
        repeat (3) cyc(1'b0, 16'h0000);
        chk("reset_we",   32'(write_enable),  32'h0);
        chk("reset_addr", 32'(write_address), 32'h0);
        chk("reset_ri",   32'(read_index),    32'h0);
        reset = 1'b0;

        // Rising at 0, no decimation: -5, -3, +2 triggers on +2
        base = wr_cnt;
        cyc(1'b1, 16'hFFFB);
        cyc(1'b1, 16'hFFFD);
        cyc(1'b1, 16'h0002);
        chk("first_we",   32'(write_enable),  32'h1);
        chk("first_addr", 32'(write_address), 32'h100);
        chk("first_data", 32'(write_sample),  32'h80);
        for (int i = 0; i < N - 1; i++) cyc(1'b1, 16'($urandom));
        chk("last_done", 32'(capture_done),  32'h1);
        chk("last_addr", 32'(write_address), 32'h1FF);
        cyc(1'b0, 16'h0000);
        chk("rising_writes", 32'(wr_cnt - base), 32'd256);
        wave_display_idle = 1'b1;
        cyc(1'b0, 16'h0000);
        wave_display_idle = 1'b0;
        chk("ri_after_idle", 32'(read_index), 32'h1);

        // Falling at 0x1000 into bank 0
        trig_falling = 1'b1; trig_threshold = 16'h1000;
        cyc(1'b1, 16'h2000);
        chk("fall_no_early", 32'(write_enable), 32'h0);
        cyc(1'b1, 16'h0800);
        chk("fall_we",   32'(write_enable),  32'h1);
        chk("fall_addr", 32'(write_address), 32'h000);
        chk("fall_data", 32'(write_sample),  32'h88);
        got = 1'b0;
        for (int i = 0; i < 3000 && !got; i++) begin
            cyc(1'($urandom % 2), 16'($urandom));
            if (capture_done) got = 1'b1;
        end
        chk("fall_capture_done", 32'(got), 32'h1);

        // Parked in WAIT with the display busy
        cyc(1'b0, 16'h0000);
        base = wr_cnt;
        for (int i = 0; i < 999; i++) cyc(1'b1, 16'($urandom));
        cyc(1'b1, 16'h2000);
        cyc(1'b0, 16'h0000);
        chk("wait_no_writes", 32'(wr_cnt - base), 32'h0);
        chk("wait_ri_stable", 32'(read_index),    32'h1);
        wave_display_idle = 1'b1;
        cyc(1'b1, 16'h0800);
        wave_display_idle = 1'b0;
        chk("idle_coincident_no_trig", 32'(write_enable), 32'h0);
        chk("idle_ri_toggle",          32'(read_index),   32'h0);
        for (int i = 0; i < 40; i++) cyc(1'b1, 16'(32'h0800 + i * 32'h100));
        cyc(1'b0, 16'h0000);
        chk("rising_seq_no_fall", 32'(wr_cnt - base), 32'h0);

        // Decimation by 4; changing decim mid-capture has no effect
        trig_falling = 1'b0; trig_threshold = 16'h0000; decim = 8'd3;
        cyc(1'b1, 16'hFF9C);
        base = wr_cnt;
        cyc(1'b1, 16'h0064);
        chk("decim_trig_addr", 32'(write_address), 32'h100);
        for (int i = 1; i < 4; i++) cyc(1'b1, 16'($urandom));
        chk("decim_skip", 32'(write_enable), 32'h0);
        cyc(1'b1, 16'($urandom));
        chk("decim_pulse4_we",   32'(write_enable),  32'h1);
        chk("decim_pulse4_addr", 32'(write_address), 32'h101);
        decim = 8'd0;
        for (int i = 0; i < 1016; i++) cyc(1'b1, 16'($urandom));
        chk("decim_done", 32'(capture_done), 32'h1);
        cyc(1'b0, 16'h0000);
        chk("decim_writes", 32'(wr_cnt - base), 32'd256);
        wave_display_idle = 1'b1;
        cyc(1'b0, 16'h0000);
        wave_display_idle = 1'b0;

        // Reset in the middle of a capture
        cyc(1'b1, 16'hFFCE);
        cyc(1'b1, 16'h0032);
        chk("mid_trig_addr", 32'(write_address), 32'h000);
        for (int i = 0; i < 100; i++) cyc(1'b1, 16'($urandom));
        chk("mid_idx100", 32'(write_address), 32'd100);
        reset = 1'b1;
        cyc(1'b0, 16'h0000);
        reset = 1'b0;
        chk("rst_we",   32'(write_enable),   32'h0);
        chk("rst_addr", 32'(write_address),  32'h0);
        chk("rst_data", 32'(write_sample),   32'h0);
        chk("rst_ri",   32'(read_index),     32'h0);
        chk("rst_auto", 32'(auto_triggered), 32'h0);

        // Auto-trigger on constant zero input
        auto_en = 1'b1;
        for (int i = 0; i < AT - 1; i++) cyc(1'b1, 16'h0000);
        chk("auto_not_yet", 32'(write_enable), 32'h0);
        cyc(1'b1, 16'h0000);
        chk("auto_we",   32'(write_enable),   32'h1);
        chk("auto_flag", 32'(auto_triggered), 32'h1);
        chk("auto_addr", 32'(write_address),  32'h100);
        chk("auto_data", 32'(write_sample),   32'h80);
        for (int i = 0; i < N - 1; i++) cyc(1'b1, 16'h0000);
        chk("auto_done", 32'(capture_done), 32'h1);
        wave_display_idle = 1'b1;
        cyc(1'b0, 16'h0000);
        wave_display_idle = 1'b0;
        auto_en = 1'b0;
        base = wr_cnt;
        for (int i = 0; i < 200; i++) cyc(1'b1, 16'h0000);
        cyc(1'b0, 16'h0000);
        chk("auto_off_no_writes", 32'(wr_cnt - base), 32'h0);

        // Randomized soak against the model
        for (int c = 0; c < 15000; c++) begin
            if (c % 500 == 0) begin
                trig_threshold = 16'($urandom);
                trig_falling   = 1'($urandom % 2);
                auto_en        = 1'($urandom % 2);
                decim          = 8'($urandom_range(0, 2));
            end
            wave_display_idle = ($urandom % 8) == 0;
            reset             = ($urandom % 4000) == 0;
            cyc(1'(($urandom % 3) != 0), 16'($urandom));
        end
        reset = 1'b0;
        wave_display_idle = 1'b0;
        cyc(1'b0, 16'h0000);
        cyc(1'b0, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
